// File: rtl/mc_mem_if.sv
// Memory strobe/response bundle between the multicycle datapath and memory.
// The master side issues strobes; the slave side answers with a ready pulse.
interface mc_mem_if;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        mem_ready;
    logic        mem_err;

    modport master (
        output mem_read, mem_write, addr, wdata,
        input  rdata, mem_ready, mem_err
    );

    modport slave (
        input  mem_read, mem_write, addr, wdata,
        output rdata, mem_ready, mem_err
    );
endinterface

// File: rtl/mc_mem_responder.sv
// Unified word memory with programmable read/write wait states.
// Each accepted request completes once with a registered ready pulse.
module mc_mem_responder #(
    parameter int DEPTH_LOG2 = 10,
    parameter int READ_LAT   = 2,
    parameter int WRITE_LAT  = 1
) (
    input logic     clk,
    input logic     rst,
    mc_mem_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RBUSY, WBUSY, DONE} state_t;

    localparam logic [3:0] RD_LOAD = 4'(READ_LAT - 1);
    localparam logic [3:0] WR_LOAD = 4'(WRITE_LAT - 1);

    state_t                  state, state_n;
    logic [3:0]              cnt, cnt_n;
    logic [DEPTH_LOG2-1:0]   cap_idx, cap_idx_n;
    logic [31:0]             cap_wdata, cap_wdata_n;
    logic                    cap_err, cap_err_n;
    logic                    ready_q, ready_n;
    logic                    err_q, err_n;
    logic [31:0]             rdata_q, rdata_n;
    logic                    wr_en;
    logic                    req_err;

    logic [31:0] ram [2**DEPTH_LOG2];

    assign bus.mem_ready = ready_q;
    assign bus.mem_err   = err_q;
    assign bus.rdata     = rdata_q;

    // Illegal address: misaligned or beyond the implemented word range.
    assign req_err = (bus.addr[1:0] != 2'b00)
                   || ((bus.addr >> (DEPTH_LOG2 + 2)) != 32'd0);

    // State, capture and output registers; reset aborts any transaction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            cap_idx   <= '0;
            cap_wdata <= 32'd0;
            cap_err   <= 1'b0;
            ready_q   <= 1'b0;
            err_q     <= 1'b0;
            rdata_q   <= 32'd0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            cap_idx   <= cap_idx_n;
            cap_wdata <= cap_wdata_n;
            cap_err   <= cap_err_n;
            ready_q   <= ready_n;
            err_q     <= err_n;
            rdata_q   <= rdata_n;
        end
    end

    // Next-state, capture and completion logic.
    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        cap_idx_n   = cap_idx;
        cap_wdata_n = cap_wdata;
        cap_err_n   = cap_err;
        ready_n     = 1'b0;
        err_n       = 1'b0;
        rdata_n     = rdata_q;
        wr_en       = 1'b0;
        case (state)
            IDLE: begin
                if (bus.mem_read || bus.mem_write) begin
                    cap_idx_n   = bus.addr[DEPTH_LOG2+1:2];
                    cap_wdata_n = bus.wdata;
                    if (bus.mem_read && !bus.mem_write) begin
                        state_n   = RBUSY;
                        cnt_n     = RD_LOAD;
                        cap_err_n = req_err;
                    end else begin
                        // A lone write or a both-strobe collision.
                        state_n   = WBUSY;
                        cnt_n     = WR_LOAD;
                        cap_err_n = req_err || bus.mem_read;
                    end
                end
            end
            RBUSY, WBUSY: begin
                if (cnt == 4'd0) begin
                    state_n = DONE;
                    ready_n = 1'b1;
                    err_n   = cap_err;
                    if (state == RBUSY)
                        rdata_n = cap_err ? 32'd0 : ram[cap_idx];
                    else
                        wr_en = !cap_err;
                end else begin
                    cnt_n = cnt - 4'd1;
                end
            end
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // RAM write port; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en)
            ram[cap_idx] <= cap_wdata;
    end
endmodule

// File: doc/mc_mem_responder.md
# mc_mem_responder

Word-addressed unified instruction/data memory that serves the multicycle core's memory strobes (`mem_read`, `mem_write`) with programmable wait states and a `mem_ready` completion handshake. It sits on the memory side of the datapath's address/write-data path, replacing the zero-latency memory model so that the controller can be made stall-aware. Every accepted request completes exactly once, with a one-cycle `mem_ready` pulse and an error flag for illegal accesses.

## Interface
- `DEPTH_LOG2`, 10: memory holds 2^DEPTH_LOG2 32-bit words.
- `READ_LAT`, 2: cycles from request acceptance to read completion; legal range 1..15.
- `WRITE_LAT`, 1: cycles from request acceptance to write completion; legal range 1..15.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset, asynchronous and active-high.
- `mem_read`  in  1  read request level.
- `mem_write`  in  1  write request level.
- `addr`  in  32  byte address from the datapath's PC/ALUOut mux.
- `wdata`  in  32  store data (register B).
- `rdata`  out  32  read data; valid while `mem_ready`=1 after a read, then held.
- `mem_ready`  out  1  one-cycle completion pulse.
- `mem_err`  out  1  qualifies `mem_ready`: the completing access was illegal.

## Operation
- FSM states: IDLE, RBUSY, WBUSY, DONE. The state is registered, and all outputs are registered.
- IDLE:
  - If exactly one of `mem_read`/`mem_write` is 1 at the edge, capture `addr`, `wdata`, the request type and an error bit.
  - Load the latency counter with LAT-1 and go to RBUSY or WBUSY.
- Both strobes at 1 in IDLE:
  - Accept as an illegal access and go to WBUSY with the error bit set and LAT=WRITE_LAT.
  - No memory access occurs.
- Error bit: set for `addr[1:0]` != 0, for `addr[31:DEPTH_LOG2+2]` != 0, or for simultaneous strobes.
- RBUSY/WBUSY:
  - The counter decrements each edge.
  - At the edge where the counter equals 0, go to DONE.
- Entering DONE:
  - Set `mem_ready`=1 and `mem_err`=error bit.
  - Read without error: `rdata` = mem[`addr[DEPTH_LOG2+1:2]`].
  - Read with error: `rdata` = 0.
  - Write without error: commit `wdata` to the RAM at this edge.
  - Write with error: drop the write.
- DONE: lasts exactly one cycle, then return to IDLE unconditionally.
- Captured values rule: once a request is accepted, strobe or `addr`/`wdata` changes during RBUSY/WBUSY/DONE are ignored, and the transaction completes with the captured values.
- Requester rule: deassert the strobe in the DONE cycle. A strobe still high in IDLE after DONE is treated as a new request.
- RAM contents are not reset. Simulation initialisation is outside this block.

## Timing
- Reset values (asserted asynchronously):
  - state = IDLE
  - `mem_ready` = 0
  - `mem_err` = 0
  - `rdata` = 0
  - counter = 0
  - capture registers = 0
- Request sampled at edge E0 → `mem_ready` is high in the cycle following edge E0+LAT.
  - READ_LAT=1: ready in the cycle after E0+1.
  - READ_LAT=2: ready in the cycle after E0+2.
- Throughput: at most one transaction per LAT+2 cycles (accept, LAT busy edges, DONE, IDLE bubble).
- `rdata` holds its last value until the next read completes. Writes and errors do not change it, except that an errored read drives 0.
- Reset mid-operation: the transaction is aborted and no `mem_ready` is produced. A write whose commit edge has not yet occurred is not committed.
- Reset release: the first request can be accepted at the first rising edge after `rst` falls.

## Test plan
- Reset asserted mid-cycle while in RBUSY → outputs go to 0 immediately. After release, `mem_read`@0x0 with READ_LAT=2 completes after exactly 2 busy edges.
- `mem_write` @0x10 with `wdata`=0xDEADBEEF (WRITE_LAT=1), then `mem_read` @0x10 → one `mem_ready` pulse each, `mem_err`=0, read `rdata`=0xDEADBEEF, and a one-cycle IDLE gap between the two.
- `mem_read` @0x6 (misaligned) → `mem_ready`=1, `mem_err`=1, `rdata`=0.
- `mem_write` @0x1000 with DEPTH_LOG2=10 → `mem_err`=1, and a subsequent read of word 0 is unchanged.
- `mem_read` and `mem_write` both high → error completion after WRITE_LAT, and no RAM change.
- Read accepted, then `addr` changed to 0x20 and the strobe dropped during RBUSY → `rdata` still returns the contents of the originally captured address, and `mem_ready` pulses once.
- Strobe held high through DONE → a second transaction is accepted at the IDLE edge, producing two separate `mem_ready` pulses.
